// File: rtl/jtpopeye_dma.sv
// Popeye object DMA: on each LVBL fall, takes the Z80 bus and copies LEN bytes of
// main RAM from BASE into the object buffer. Optional XOR checksum: JTPOPEYE_DMA_CHKSUM_EN.
module jtpopeye_dma #(
    parameter logic [10:0] BASE = 11'h400,
    parameter logic [9:0]  LEN  = 10'd640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cen,
    input  logic        LVBL,
    input  logic        busak_n,
    output logic        bus_req,
    output logic        DMCS,
    output logic [10:0] dma_addr,
    input  logic [7:0]  ram_data,
    output logic [9:0]  obj_addr,
    output logic [7:0]  obj_data,
    output logic        obj_we,
    output logic        busy,
    output logic [7:0]  chksum
);

    typedef enum logic [2:0] {IDLE, REQ, COPY, DRAIN, REL} state_t;

    localparam logic [9:0] LAST = LEN - 10'd1;

    state_t      state_q, state_d;
    logic        lvbl_q, lvbl_d;
    logic        lvbl_l_q, lvbl_l_d;
    logic [9:0]  n_q, n_d;
    logic [9:0]  n_inc;
    logic [10:0] dma_addr_q, dma_addr_d;
    logic [9:0]  obj_addr_q, obj_addr_d;
    logic [7:0]  obj_data_q, obj_data_d;
    logic        obj_we_q, obj_we_d;
    logic        bus_req_q, bus_req_d;
    logic        dmcs_q, dmcs_d;
    logic        busy_q, busy_d;

    assign n_inc = n_q + 10'd1;

    always_comb begin
        state_d    = state_q;
        lvbl_d     = lvbl_q;
        lvbl_l_d   = lvbl_l_q;
        n_d        = n_q;
        dma_addr_d = dma_addr_q;
        obj_addr_d = obj_addr_q;
        obj_data_d = obj_data_q;
        obj_we_d   = obj_we_q;
        bus_req_d  = bus_req_q;
        dmcs_d     = dmcs_q;
        busy_d     = busy_q;
        if (cpu_cen) begin
            // Two-stage LVBL sampling: the fall is acted on one cen after it is sampled
            lvbl_d   = LVBL;
            lvbl_l_d = lvbl_q;
            obj_we_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (lvbl_l_q && !lvbl_q) state_d = REQ;
                end
                REQ: begin
                    if (!busak_n) begin
                        state_d    = COPY;
                        n_d        = 10'd0;
                        dma_addr_d = BASE;
                    end else if (LVBL) begin
                        state_d = IDLE;
                    end
                end
                COPY: begin
                    // Data on ram_data belongs to the address issued on the previous cen
                    obj_we_d   = 1'b1;
                    obj_addr_d = n_q;
                    obj_data_d = ram_data;
                    if (n_q == LAST) begin
                        state_d = DRAIN;
                    end else begin
                        n_d        = n_inc;
                        dma_addr_d = BASE + {1'b0, n_inc};
                    end
                end
                DRAIN:   state_d = REL;
                REL:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
            bus_req_d = (state_d == REQ) || (state_d == COPY) || (state_d == DRAIN);
            dmcs_d    = (state_d == COPY) || (state_d == DRAIN);
            busy_d    = bus_req_d || (state_d == REL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lvbl_q     <= 1'b1;
            lvbl_l_q   <= 1'b1;
            n_q        <= 10'd0;
            dma_addr_q <= 11'd0;
            obj_addr_q <= 10'd0;
            obj_data_q <= 8'd0;
            obj_we_q   <= 1'b0;
            bus_req_q  <= 1'b0;
            dmcs_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvbl_q     <= lvbl_d;
            lvbl_l_q   <= lvbl_l_d;
            n_q        <= n_d;
            dma_addr_q <= dma_addr_d;
            obj_addr_q <= obj_addr_d;
            obj_data_q <= obj_data_d;
            obj_we_q   <= obj_we_d;
            bus_req_q  <= bus_req_d;
            dmcs_q     <= dmcs_d;
            busy_q     <= busy_d;
        end
    end

`ifdef JTPOPEYE_DMA_CHKSUM_EN
    logic [7:0] acc_q, acc_d;
    logic [7:0] chksum_q, chksum_d;

    // Accumulator restarts on COPY entry; result is published on REL entry
    always_comb begin
        acc_d    = acc_q;
        chksum_d = chksum_q;
        if (cpu_cen) begin
            if (state_q == REQ && !busak_n) acc_d = 8'd0;
            else if (state_q == COPY)       acc_d = acc_q ^ ram_data;
            if (state_q == DRAIN) chksum_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= 8'd0;
            chksum_q <= 8'd0;
        end else begin
            acc_q    <= acc_d;
            chksum_q <= chksum_d;
        end
    end

    assign chksum = chksum_q;
`else
    assign chksum = 8'h00;
`endif

    assign bus_req  = bus_req_q;
    assign DMCS     = dmcs_q;
    assign dma_addr = dma_addr_q;
    assign obj_addr = obj_addr_q;
    assign obj_data = obj_data_q;
    assign obj_we   = obj_we_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Bench for jtpopeye_dma: a default instance (BASE=400, LEN=640) and a small
// wrap-around instance (BASE=7FE, LEN=4) driven from a vector table.
module tb_jtpopeye_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        lvbl = 1'b1, busak_n = 1'b1;
    logic        lvbl2 = 1'b1, busak2_n = 1'b1;
    logic        bus_req, dmcs, obj_we, busy;
    logic [10:0] dma_addr;
    logic [9:0]  obj_addr;
    logic [7:0]  obj_data, chksum, ram_data;
    logic        bus_req2, dmcs2, obj_we2, busy2;
    logic [10:0] dma_addr2;
    logic [9:0]  obj_addr2;
    logic [7:0]  obj_data2, chksum2, ram_data2;
    logic [7:0]  mem [0:2047];

    int total = 0;
    int bad = 0;

`ifdef JTPOPEYE_DMA_CHKSUM_EN
    localparam logic [7:0] CHK_W = 8'hFF;
`else
    localparam logic [7:0] CHK_W = 8'h00;
`endif

    assign ram_data  = mem[dma_addr];
    assign ram_data2 = mem[dma_addr2];

    jtpopeye_dma u_dut (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cen), .LVBL(lvbl), .busak_n(busak_n),
        .bus_req(bus_req), .DMCS(dmcs), .dma_addr(dma_addr), .ram_data(ram_data),
        .obj_addr(obj_addr), .obj_data(obj_data), .obj_we(obj_we), .busy(busy),
        .chksum(chksum)
    );

    jtpopeye_dma #(.BASE(11'h7FE), .LEN(10'd4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cen), .LVBL(lvbl2), .busak_n(busak2_n),
        .bus_req(bus_req2), .DMCS(dmcs2), .dma_addr(dma_addr2), .ram_data(ram_data2),
        .obj_addr(obj_addr2), .obj_data(obj_data2), .obj_we(obj_we2), .busy(busy2),
        .chksum(chksum2)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cen = ~cen;

    typedef struct {
        logic        lvbl;
        logic        bk;
        logic        req;
        logic        dmcs;
        logic        busy;
        logic        we;
        logic [10:0] da;
        logic [9:0]  oa;
        logic [7:0]  od;
        logic [7:0]  ck;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        do @(posedge clk); while (cen !== 1'b1);
        #1;
    endtask

    task automatic run_copy(input bit retrig);
        int cnt;
        int writes;
        int late;
        lvbl = 1'b0;
        step();
        check("req_lat1", bus_req, 1'b0);
        step();
        check("req_lat2", bus_req, 1'b1);
        step();
        step();
        busak_n = 1'b0;
        cnt = 0;
        writes = 0;
        while (cnt < 2000) begin
            step();
            cnt++;
            if (cnt == 1) begin
                check("first_addr", dma_addr, 11'h400);
                check("first_dmcs", dmcs, 1'b1);
                check("first_we", obj_we, 1'b0);
            end
            if (retrig && cnt == 100) lvbl = 1'b1;
            if (retrig && cnt == 103) lvbl = 1'b0;
            if (obj_we) begin
                check("wr_addr", obj_addr, writes);
                check("wr_data", obj_data, writes[7:0]);
                writes++;
            end
            if (!bus_req) break;
        end
        check("hold_len", cnt, 642);
        check("writes", writes, 640);
        check("rel_busy", busy, 1'b1);
        check("rel_dmcs", dmcs, 1'b0);
        step();
        check("idle_busy", busy, 1'b0);
        check("chksum640", chksum, 8'h00);
        busak_n = 1'b1;
        late = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_req || obj_we) late++;
        end
        check("no_second_req", late, 0);
        lvbl = 1'b1;
        step();
        step();
    endtask

    initial begin
        int we_seen;
        int found;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        for (int i = 0; i < 640; i++) mem[11'h400 + i] = 8'(i);
        mem[11'h7FE] = 8'h11;
        mem[11'h7FF] = 8'h22;
        mem[11'h000] = 8'h44;
        mem[11'h001] = 8'h88;

        //            lvbl  bk    req   dmcs  busy  we    da       oa     od     ck
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 10'd0, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 10'd0, 8'h00, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'h000, 10'd0, 8'h00, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'h7FE, 10'd0, 8'h00, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h7FF, 10'd0, 8'h11, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h000, 10'd1, 8'h22, 8'h00};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h001, 10'd2, 8'h44, 8'h00};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h001, 10'd3, 8'h88, 8'h00};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h001, 10'd3, 8'h88, CHK_W};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 10'd3, 8'h88, CHK_W};

        #23;
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_dmcs", dmcs, 1'b0);
        check("rst_addr", dma_addr, 11'h000);
        check("rst_obj", {obj_addr, obj_data, obj_we}, 19'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_chksum", chksum, 8'h00);
        rst_n = 1'b1;
        step();
        step();
        check("idle_bus_req", bus_req, 1'b0);

        for (int i = 0; i < 10; i++) begin
            lvbl2 = tbl[i].lvbl;
            busak2_n = tbl[i].bk;
            step();
            check($sformatf("wrap%0d_ctl", i), {bus_req2, dmcs2, busy2, obj_we2},
                  {tbl[i].req, tbl[i].dmcs, tbl[i].busy, tbl[i].we});
            check($sformatf("wrap%0d_dma", i), dma_addr2, tbl[i].da);
            check($sformatf("wrap%0d_obj", i), {obj_addr2, obj_data2}, {tbl[i].oa, tbl[i].od});
            check($sformatf("wrap%0d_chk", i), chksum2, tbl[i].ck);
        end

        run_copy(1'b1);

        we_seen = 0;
        lvbl = 1'b0;
        step();
        step();
        check("abort_req", bus_req, 1'b1);
        for (int i = 0; i < 48; i++) begin
            step();
            if (obj_we || dmcs) we_seen++;
        end
        lvbl = 1'b1;
        step();
        check("abort_drop", bus_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_dmcs", dmcs, 1'b0);
        check("abort_we", we_seen, 0);
        step();
        step();
        check("abort_idle", {bus_req, busy}, 2'b00);

        lvbl = 1'b0;
        step();
        step();
        step();
        busak_n = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            step();
            if (obj_we && obj_addr == 10'd100) found = 1;
        end
        check("reach_byte100", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctl", {bus_req, dmcs, obj_we, busy}, 4'b0000);
        check("arst_addr", dma_addr, 11'h000);
        lvbl = 1'b1;
        busak_n = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_idle", {bus_req, busy}, 2'b00);
        run_copy(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
